// File: rtl/qed_dup_queue.sv
// SQED duplicate-instruction queue: forwards originals to decode, stores remapped copies, replays them in DUP mode.
// Optional build macro QED_PAIR_COUNT_EN adds orig/dup pair counters and the qed_check trigger.
module qed_dup_queue #(
  parameter int                       INSN_W      = 32,
  parameter int                       REG_W       = 5,
  parameter int                       DEPTH       = 8,
  parameter int                       MEM_OFS_W   = 2,
  parameter logic [MEM_OFS_W-1:0]     MEM_OFS_VAL = 2'b01,
  parameter logic [INSN_W-1:0]        NOP_INSN    = 32'h1500_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic                        stall,
  input  logic                        exec_dup,
  input  logic [INSN_W-1:0]           in_instruction,
  input  logic                        is_lw,
  input  logic                        is_sw,
  input  logic                        is_aluimm,
  input  logic                        is_alureg,
  output logic                        in_ready,
  output logic [INSN_W-1:0]           qed_instruction,
  output logic                        qed_valid,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic                        overflow
`ifdef QED_PAIR_COUNT_EN
  ,
  output logic [15:0]                 orig_count,
  output logic [15:0]                 dup_count,
  output logic                        qed_check
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake: an original transfers on a clk edge where in_valid & in_ready & !stall;
  // in_ready depends only on mode and occupancy, never on in_valid.

  logic [INSN_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [INSN_W-1:0] dup_insn;
  logic              full;
  logic              accept;
  logic              pop;
  logic              drop;

  // Index 0 is the hardwired zero register and must stay shared between halves.
  function automatic logic [4:0] remap_reg(input logic [4:0] r);
    remap_reg = r;
    if (r != 5'd0) begin
      remap_reg = '0;
      remap_reg[REG_W-1:0] = {1'b1, r[REG_W-2:0]};
    end
  endfunction

  always_comb begin
    dup_insn = in_instruction;
    if (is_lw) begin
      dup_insn[25:21]              = remap_reg(in_instruction[25:21]);
      dup_insn[20:16]              = remap_reg(in_instruction[20:16]);
      dup_insn[15 -: MEM_OFS_W]    = MEM_OFS_VAL;
    end else if (is_sw) begin
      dup_insn[25 -: MEM_OFS_W]    = MEM_OFS_VAL;
      dup_insn[20:16]              = remap_reg(in_instruction[20:16]);
      dup_insn[15:11]              = remap_reg(in_instruction[15:11]);
    end else if (is_alureg) begin
      dup_insn[25:21]              = remap_reg(in_instruction[25:21]);
      dup_insn[20:16]              = remap_reg(in_instruction[20:16]);
      dup_insn[15:11]              = remap_reg(in_instruction[15:11]);
    end else if (is_aluimm) begin
      dup_insn[25:21]              = remap_reg(in_instruction[25:21]);
      dup_insn[20:16]              = remap_reg(in_instruction[20:16]);
    end
  end

  assign full     = (fifo_count == DEPTH_C);
  assign in_ready = !exec_dup && !full;
  assign accept   = in_valid && in_ready && !stall;
  assign pop      = exec_dup && (fifo_count != '0) && !stall;
  assign drop     = in_valid && !exec_dup && full && !stall;

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= dup_insn;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      qed_instruction <= NOP_INSN;
      qed_valid       <= 1'b0;
      overflow        <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        wr_ptr          <= wr_ptr + 1'b1;
        fifo_count      <= fifo_count + 1'b1;
        qed_instruction <= in_instruction;
        qed_valid       <= 1'b1;
      end else if (pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        fifo_count      <= fifo_count - 1'b1;
        qed_instruction <= mem[rd_ptr];
        qed_valid       <= 1'b1;
      end else begin
        qed_instruction <= NOP_INSN;
        qed_valid       <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef QED_PAIR_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      orig_count <= '0;
      dup_count  <= '0;
    end else begin
      if (accept && orig_count != 16'hFFFF) orig_count <= orig_count + 1'b1;
      if (pop && dup_count != 16'hFFFF)     dup_count  <= dup_count + 1'b1;
    end
  end

  assign qed_check = (orig_count == dup_count) && (orig_count != 16'd0) &&
                     (fifo_count == '0) && !stall;
`endif

endmodule

// File: tb/tb_qed_dup_queue.sv
// Directed bench for qed_dup_queue: remap vector table plus overflow, mode-switch, stall and reset sequences.
module tb_qed_dup_queue;

  localparam logic [31:0] NOP = 32'h1500_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        stall;
  logic        exec_dup;
  logic [31:0] in_instruction;
  logic        is_lw, is_sw, is_aluimm, is_alureg;
  logic        in_ready;
  logic [31:0] qed_instruction;
  logic        qed_valid;
  logic [3:0]  fifo_count;
  logic        overflow;
`ifdef QED_PAIR_COUNT_EN
  logic [15:0] orig_count;
  logic [15:0] dup_count;
  logic        qed_check;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  qed_dup_queue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .exec_dup(exec_dup),
    .in_instruction(in_instruction), .is_lw(is_lw), .is_sw(is_sw),
    .is_aluimm(is_aluimm), .is_alureg(is_alureg), .in_ready(in_ready),
    .qed_instruction(qed_instruction), .qed_valid(qed_valid),
    .fifo_count(fifo_count), .overflow(overflow)
`ifdef QED_PAIR_COUNT_EN
    , .orig_count(orig_count), .dup_count(dup_count), .qed_check(qed_check)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; exec_dup = 1'b0;
    in_instruction = '0; {is_lw, is_sw, is_alureg, is_aluimm} = 4'b0000;
    step(); step();
    rst_n = 1'b1;
  endtask

  // driver
  task automatic drive_orig(input logic [31:0] insn, input logic [3:0] cls);
    in_valid = 1'b1; exec_dup = 1'b0;
    in_instruction = insn;
    {is_lw, is_sw, is_alureg, is_aluimm} = cls;
  endtask

  task automatic drive_idle(input logic dup);
    in_valid = 1'b0; exec_dup = dup;
    {is_lw, is_sw, is_alureg, is_aluimm} = 4'b0000;
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] insn;
    logic [3:0]  cls;   // {lw, sw, alureg, aluimm}
    logic [31:0] dup;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'hE061_1000, 4'b0010, 32'hE271_9000}; // l.add r3,r1,r2
    vecs[1] = '{32'h8485_0008, 4'b1000, 32'h8695_4008}; // l.lwz r4,8(r5)
    vecs[2] = '{32'h8480_0008, 4'b1000, 32'h8680_4008}; // l.lwz r4,8(r0)
    vecs[3] = '{32'h9C61_1234, 4'b0001, 32'h9E71_1234}; // l.addi r3,r1,0x1234
    vecs[4] = '{32'hD7E1_1005, 4'b0100, 32'hD5F1_9005}; // l.sw with imm hi 11111
    vecs[5] = '{32'h1234_5678, 4'b0000, 32'h1234_5678}; // unclassified
    vecs[6] = '{32'hE000_0000, 4'b0010, 32'hE000_0000}; // r0 operands

    do_reset();
    chk("rst_qed", qed_instruction, NOP);
    chk("rst_valid", {31'b0, qed_valid}, 32'd0);
    chk("rst_count", {28'b0, fifo_count}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);

    // remap table: enqueue one, replay one, idle one
    for (int i = 0; i < 7; i++) begin
      drive_orig(vecs[i].insn, vecs[i].cls);
      step();
      chk($sformatf("v%0d_orig", i), qed_instruction, vecs[i].insn);
      chk($sformatf("v%0d_ovalid", i), {31'b0, qed_valid}, 32'd1);
      chk($sformatf("v%0d_cnt1", i), {28'b0, fifo_count}, 32'd1);
      drive_idle(1'b1);
      step();
      chk($sformatf("v%0d_dup", i), qed_instruction, vecs[i].dup);
      chk($sformatf("v%0d_cnt0", i), {28'b0, fifo_count}, 32'd0);
      drive_idle(1'b0);
      step();
      chk($sformatf("v%0d_nop", i), qed_instruction, NOP);
      chk($sformatf("v%0d_nvalid", i), {31'b0, qed_valid}, 32'd0);
    end

    // overflow: DEPTH+1 originals, then full drain in order
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_orig(32'hA000_0000 + i, 4'b0000);
      #1;
      chk($sformatf("ovf_ready%0d", i), {31'b0, in_ready}, (i < 8) ? 32'd1 : 32'd0);
      step();
      if (i < 8) begin
        exp_q.push_back(32'hA000_0000 + i);
        chk($sformatf("ovf_q%0d", i), qed_instruction, 32'hA000_0000 + i);
        chk($sformatf("ovf_cnt%0d", i), {28'b0, fifo_count}, i + 1);
        chk($sformatf("ovf_flag%0d", i), {31'b0, overflow}, 32'd0);
      end else begin
        chk("ovf_drop_q", qed_instruction, NOP);
        chk("ovf_drop_v", {31'b0, qed_valid}, 32'd0);
        chk("ovf_set", {31'b0, overflow}, 32'd1);
      end
    end
    drive_idle(1'b1);
    #1;
    chk("dup_ready", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("drain%0d", k), qed_instruction, exp_q.pop_front());
      chk($sformatf("drain_cnt%0d", k), {28'b0, fifo_count}, 7 - k);
    end
    step();
    chk("drain_end_q", qed_instruction, NOP);
    chk("drain_end_v", {31'b0, qed_valid}, 32'd0);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);

    // split DUP windows preserve order; in_valid ignored in DUP
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive_orig(32'hB000_0000 + i, 4'b0000);
      step();
    end
    chk("sw_cnt3", {28'b0, fifo_count}, 32'd3);
    drive_idle(1'b1);
    step();
    chk("sw_c1", qed_instruction, 32'hB000_0001);
    chk("sw_cnt2a", {28'b0, fifo_count}, 32'd2);
    drive_idle(1'b0);
    step();
    chk("sw_gap", qed_instruction, NOP);
    chk("sw_cnt2b", {28'b0, fifo_count}, 32'd2);
    drive_idle(1'b1);
    in_valid = 1'b1; in_instruction = 32'hDEAD_BEEF;
    step();
    chk("sw_c2", qed_instruction, 32'hB000_0002);
    chk("sw_cnt1", {28'b0, fifo_count}, 32'd1);
    step();
    chk("sw_c3", qed_instruction, 32'hB000_0003);
    chk("sw_cnt0", {28'b0, fifo_count}, 32'd0);
    step();
    chk("sw_empty_v", {31'b0, qed_valid}, 32'd0);
    chk("sw_no_ovf", {31'b0, overflow}, 32'd0);

    // stall in ORIG mode blocks accept
    drive_orig(32'hC000_0000, 4'b0000);
    stall = 1'b1;
    step();
    chk("st_orig_cnt", {28'b0, fifo_count}, 32'd0);
    stall = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive_orig(32'hC000_0000 + i, 4'b0000);
      step();
    end
    drive_idle(1'b1);
    step();
    chk("st_c1", qed_instruction, 32'hC000_0001);
    stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      chk($sformatf("st_hold%0d", s), qed_instruction, 32'hC000_0001);
      chk($sformatf("st_cnt%0d", s), {28'b0, fifo_count}, 32'd2);
    end
    stall = 1'b0;
    step();
    chk("st_c2", qed_instruction, 32'hC000_0002);
    rst_n = 1'b0; exec_dup = 1'b0;
    step();
    chk("mr_cnt", {28'b0, fifo_count}, 32'd0);
    chk("mr_q", qed_instruction, NOP);
    chk("mr_v", {31'b0, qed_valid}, 32'd0);
    rst_n = 1'b1; exec_dup = 1'b1;
    step();
    chk("mr_discard_v", {31'b0, qed_valid}, 32'd0);

`ifdef QED_PAIR_COUNT_EN
    do_reset();
    chk("pc_rst_chk", {31'b0, qed_check}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive_orig(32'hE000_0000 + i, 4'b0000);
      step();
      chk($sformatf("pc_enq_chk%0d", i), {31'b0, qed_check}, 32'd0);
    end
    drive_idle(1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("pc_deq_chk%0d", k), {31'b0, qed_check}, (k == 4) ? 32'd1 : 32'd0);
    end
    chk("pc_orig", {16'b0, orig_count}, 32'd5);
    chk("pc_dup", {16'b0, dup_count}, 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
